ha_array_reduce_pipe: RTL and testbench



---
 rtl/ha_array_reduce_pipe.sv | 147 ++++++++++++++
 tb/tb_ha_array_reduce_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_reduce_pipe.sv
// Final reduction of the approximate 8x8 multiplier's half-adder rows into one product word.
// Three-stage valid/ready pipeline; optional overflow counter enabled by HA_REDUCE_OVF_CNT_EN.
module ha_array_reduce_pipe #(
  parameter int OUT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic [6:0]       ha_array_3_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
`ifdef HA_REDUCE_OVF_CNT_EN
  input  logic             cnt_clr,
  output logic [15:0]      ovf_cnt,
`endif
  output logic             ovf
);

  // Wide enough that the overflow test works for every legal OUT_W (16..18).
  localparam int SUM_W = 19;

  function automatic logic [9:0] f_row(input logic [8:0] t, input logic [6:0] b);
    return {1'b0, t} + {1'b0, b, 2'b00};
  endfunction

  function automatic logic [12:0] f_pair(input logic [9:0] lo, input logic [9:0] hi);
    return {3'b000, lo} + {1'b0, hi, 2'b00};
  endfunction

  // Returns {ovf, product}; product saturates to all-ones only when SAT_EN is set.
  function automatic logic [OUT_W:0] f_reduce(input logic [SUM_W-1:0] s);
    logic             ov;
    logic [OUT_W-1:0] v;
    ov = |(s >> OUT_W);
    v  = (ov && SAT_EN) ? '1 : s[OUT_W-1:0];
    return {ov, v};
  endfunction

  logic             r_v_p1, r_v_p2, r_v_p3;
  logic [8:0]       r_t0_p1, r_t1_p1, r_t2_p1, r_t3_p1;
  logic [6:0]       r_b0_p1, r_b1_p1, r_b2_p1, r_b3_p1;
  logic [12:0]      r_a_p2, r_b_p2;
  logic [OUT_W-1:0] r_p_p3;
  logic             r_ovf_p3;

  logic             w_adv1, w_adv2, w_adv3;
  logic [SUM_W-1:0] w_sum;
  logic [OUT_W:0]   w_res;

  // Stall chain: a stage moves when it is empty or the stage after it moves.
  assign w_adv3   = !r_v_p3 | out_ready;
  assign w_adv2   = !r_v_p2 | w_adv3;
  assign w_adv1   = !r_v_p1 | w_adv2;
  assign in_ready = w_adv1;

  assign w_sum = {6'b0, r_a_p2} + {2'b0, r_b_p2, 4'b0000};
  assign w_res = f_reduce(w_sum);

  // ---- stage 1: raw rows ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_p1  <= 1'b0;
      r_t0_p1 <= '0;
      r_t1_p1 <= '0;
      r_t2_p1 <= '0;
      r_t3_p1 <= '0;
      r_b0_p1 <= '0;
      r_b1_p1 <= '0;
      r_b2_p1 <= '0;
      r_b3_p1 <= '0;
    end else if (w_adv1) begin
      r_v_p1 <= in_valid;
      if (in_valid) begin
        r_t0_p1 <= ha_array_0_t;
        r_t1_p1 <= ha_array_1_t;
        r_t2_p1 <= ha_array_2_t;
        r_t3_p1 <= ha_array_3_t;
        r_b0_p1 <= ha_array_0_b;
        r_b1_p1 <= ha_array_1_b;
        r_b2_p1 <= ha_array_2_b;
        r_b3_p1 <= ha_array_3_b;
      end
    end
  end

  // ---- stage 2: pairwise partial sums A = R0 + 4*R1, B = R2 + 4*R3 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_p2 <= 1'b0;
      r_a_p2 <= '0;
      r_b_p2 <= '0;
    end else if (w_adv2) begin
      r_v_p2 <= r_v_p1;
      if (r_v_p1) begin
        r_a_p2 <= f_pair(f_row(r_t0_p1, r_b0_p1), f_row(r_t1_p1, r_b1_p1));
        r_b_p2 <= f_pair(f_row(r_t2_p1, r_b2_p1), f_row(r_t3_p1, r_b3_p1));
      end
    end
  end

  // ---- stage 3: final sum A + 16*B, overflow and saturation ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_p3   <= 1'b0;
      r_p_p3   <= '0;
      r_ovf_p3 <= 1'b0;
    end else if (w_adv3) begin
      r_v_p3 <= r_v_p2;
      if (r_v_p2) begin
        r_p_p3   <= w_res[OUT_W-1:0];
        r_ovf_p3 <= w_res[OUT_W];
      end
    end
  end

  assign out_valid = r_v_p3;
  assign p         = r_p_p3;
  assign ovf       = r_ovf_p3;

`ifdef HA_REDUCE_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Clear has priority over a coincident increment; count sticks at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (r_v_p3 && out_ready && r_ovf_p3 && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_ha_array_reduce_pipe.sv
// Directed and random bench for ha_array_reduce_pipe; a saturating and a truncating
// instance share the same stimulus and are checked against one expected-value queue.
module tb_ha_array_reduce_pipe;

  typedef struct packed {
    logic [15:0] ps;
    logic [15:0] pt;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [8:0]  t_in [4];
  logic [6:0]  b_in [4];

  logic        in_ready_s, in_ready_t;
  logic        out_valid_s, out_valid_t;
  logic [15:0] p_s, p_t;
  logic        ovf_s, ovf_t;
`ifdef HA_REDUCE_OVF_CNT_EN
  logic [15:0] cnt_s, cnt_t;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  int   spur;
  int   lat;
  logic [3:0][8:0] rt;
  logic [3:0][6:0] rb;
  bit   rnd_done;

  always #5 clk = ~clk;

  ha_array_reduce_pipe #(.OUT_W(16), .SAT_EN(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .ha_array_0_t(t_in[0]), .ha_array_0_b(b_in[0]),
    .ha_array_1_t(t_in[1]), .ha_array_1_b(b_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_2_b(b_in[2]),
    .ha_array_3_t(t_in[3]), .ha_array_3_b(b_in[3]),
    .out_valid(out_valid_s), .out_ready(out_ready), .p(p_s),
`ifdef HA_REDUCE_OVF_CNT_EN
    .cnt_clr(cnt_clr), .ovf_cnt(cnt_s),
`endif
    .ovf(ovf_s)
  );

  ha_array_reduce_pipe #(.OUT_W(16), .SAT_EN(1'b0)) u_dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .ha_array_0_t(t_in[0]), .ha_array_0_b(b_in[0]),
    .ha_array_1_t(t_in[1]), .ha_array_1_b(b_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_2_b(b_in[2]),
    .ha_array_3_t(t_in[3]), .ha_array_3_b(b_in[3]),
    .out_valid(out_valid_t), .out_ready(out_ready), .p(p_t),
`ifdef HA_REDUCE_OVF_CNT_EN
    .cnt_clr(cnt_clr), .ovf_cnt(cnt_t),
`endif
    .ovf(ovf_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] ps, input logic [15:0] pt, input logic o);
    exp_t e;
    e.ps = ps;
    e.pt = pt;
    e.o  = o;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    int   s;
    exp_t e;
    s = 0;
    for (int k = 0; k < 4; k++) s += (int'(t[k]) + (int'(b[k]) << 2)) << (2 * k);
    e.o  = (s >= 65536);
    e.pt = s[15:0];
    e.ps = e.o ? 16'hFFFF : s[15:0];
    return e;
  endfunction

  task automatic set_rows(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    for (int k = 0; k < 4; k++) begin
      t_in[k] = t[k];
      b_in[k] = b[k];
    end
  endtask

  task automatic wait_acc();
    bit acc = 1'b0;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_s;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic send(input logic [3:0][8:0] t, input logic [3:0][6:0] b, input exp_t e);
    set_rows(t, b);
    cur_exp  = e;
    in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (out_valid_s && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid_s, 0);
        end else begin
          e = exp_q.pop_front();
          chk("p_sat", p_s, e.ps);
          chk("ovf_sat", ovf_s, e.o);
          chk("vld_trunc", out_valid_t, out_valid_s);
          chk("p_trunc", p_t, e.pt);
          chk("ovf_trunc", ovf_t, e.o);
        end
      end
      if (in_valid && in_ready_s) exp_q.push_back(cur_exp);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    cur_exp   = '0;
    set_rows('0, '0);
    #12;
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_p", p_s, 0);
    chk("rst_ovf", ovf_s, 0);
    chk("rst_in_ready", in_ready_s, 1);
`ifdef HA_REDUCE_OVF_CNT_EN
    chk("rst_ovf_cnt", cnt_s, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single entry, latency counted from the cycle it is presented.
    set_rows(36'd1, 28'd0);
    cur_exp  = mk(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_s && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("t1_p", p_s, 16'h0001);
    chk("t1_ovf", ovf_s, 0);
    @(posedge clk); #1;
    chk("t1_single_pulse", out_valid_s, 0);

    // Weight checks on the top carry row and a low carry bit.
    send(36'd0, {7'h40, 21'd0}, mk(16'h4000, 16'h4000, 1'b0));
    send(36'd0, {14'd0, 7'h01, 7'd0}, mk(16'h0010, 16'h0010, 1'b0));
    // All ones: 86615 saturates or wraps to 0x5257.
    send({4{9'h1FF}}, {4{7'h7F}}, mk(16'hFFFF, 16'h5257, 1'b1));
    drain();

    // Backpressure: three fill the pipe, the fourth waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(36'd1, 28'd0, mk(16'd1, 16'd1, 1'b0));
    send(36'd2, 28'd0, mk(16'd2, 16'd2, 1'b0));
    send(36'd3, 28'd0, mk(16'd3, 16'd3, 1'b0));
    set_rows(36'd4, 28'd0);
    cur_exp  = mk(16'd4, 16'd4, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready_s, 0);
    chk("bp_out_valid", out_valid_s, 1);
    chk("bp_p_head", p_s, 16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_p_stable", p_s, 16'd1);
    chk("bp_in_ready_still_low", in_ready_s, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_acc();
    in_valid = 1'b0;
    drain();

    // Random stream with random backpressure and idle gaps.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          for (int k = 0; k < 4; k++) begin
            rt[k] = 9'($urandom_range(0, 511));
            rb[k] = 7'($urandom_range(0, 127));
          end
          if (n % 10 == 0) begin
            rt = {4{9'h1FF}};
            rb = {4{7'h7F}};
          end
          send(rt, rb, model(rt, rb));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two entries in flight: both are discarded.
    out_ready = 1'b0;
    send(36'd5, 28'd0, mk(16'd5, 16'd5, 1'b0));
    send(36'd6, 28'd0, mk(16'd6, 16'd6, 1'b0));
    @(posedge clk); #2;
    chk("pre_rst_out_valid", out_valid_s, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid_s, 0);
    chk("async_rst_p", p_s, 0);
    chk("async_rst_in_ready", in_ready_s, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    spur      = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_s) spur++;
    end
    chk("no_out_after_rst", spur, 0);

`ifdef HA_REDUCE_OVF_CNT_EN
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send({4{9'h1FF}}, {4{7'h7F}}, mk(16'hFFFF, 16'h5257, 1'b1));
    drain();
    chk("ovf_cnt_sat", cnt_s, 3);
    chk("ovf_cnt_trunc", cnt_t, 3);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("ovf_cnt_clr", cnt_s, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
